// File: rtl/ins_mem_loader.sv
// Program loader: assembles UART bytes big-endian into instruction words,
// then serves registered instruction fetches from the loaded image.
module ins_mem_loader #(
    parameter int INS_WIDTH = 16,
    parameter int DEPTH     = 16,
    localparam int BYTES    = INS_WIDTH / 8,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Load_INS_en_in,
    input  logic                 Rx_Valid_in,
    input  logic [7:0]           Rx_Byte_in,
    input  logic [ADDR_W-1:0]    PC_in,
    output logic [INS_WIDTH-1:0] INS_out,
    output logic [ADDR_W:0]      Ins_Count_out,
    output logic                 Ready_out,
    output logic                 Overflow_out
);

    localparam int BC_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t                 state_reg;
    logic [BC_W-1:0]        byte_cnt_reg;
    logic [INS_WIDTH-1:0]   asm_reg;
    logic [ADDR_W:0]        count_reg;
    logic                   overflow_reg;
    logic                   ready_reg;
    logic [INS_WIDTH-1:0]   ins_reg;
    logic [INS_WIDTH-1:0]   mem [DEPTH];

    logic                   full;
    logic                   last_byte;
    logic                   mem_we;
    logic                   rd_ok;
    logic [BC_W-1:0]        lane;
    logic [INS_WIDTH-1:0]   assembled;

    assign full      = (count_reg == (ADDR_W+1)'(DEPTH));
    assign last_byte = (byte_cnt_reg == BC_W'(BYTES - 1));
    assign mem_we    = (state_reg == LOAD) && Load_INS_en_in && Rx_Valid_in
                       && !full && last_byte;
    assign lane      = BC_W'(BYTES - 1) - byte_cnt_reg;

    // Reads are gated on the next state so INS_out is already 0 in the
    // first cycle after READY -> LOAD, and stale or unwritten words never leak.
    assign rd_ok = (state_reg == READY) && !Load_INS_en_in
                   && ({1'b0, PC_in} < count_reg);

    always_comb begin
        assembled = asm_reg;
        assembled[{lane, 3'b000} +: 8] = Rx_Byte_in;
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[count_reg[ADDR_W-1:0]] <= assembled;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
            asm_reg      <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            ready_reg    <= 1'b0;
            ins_reg      <= '0;
        end else begin
            ins_reg <= rd_ok ? mem[PC_in] : '0;
            case (state_reg)
                IDLE, READY: begin
                    if (Load_INS_en_in) begin
                        state_reg    <= LOAD;
                        ready_reg    <= 1'b0;
                        byte_cnt_reg <= '0;
                        asm_reg      <= '0;
                        count_reg    <= '0;
                        overflow_reg <= 1'b0;
                    end
                end
                LOAD: begin
                    if (!Load_INS_en_in) begin
                        // Any partially assembled word is discarded here.
                        state_reg    <= READY;
                        ready_reg    <= 1'b1;
                        byte_cnt_reg <= '0;
                        asm_reg      <= '0;
                    end else if (Rx_Valid_in) begin
                        if (full) begin
                            overflow_reg <= 1'b1;
                        end else if (last_byte) begin
                            count_reg    <= count_reg + 1'b1;
                            byte_cnt_reg <= '0;
                            asm_reg      <= '0;
                        end else begin
                            asm_reg      <= assembled;
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign INS_out       = ins_reg;
    assign Ins_Count_out = count_reg;
    assign Ready_out     = ready_reg;
    assign Overflow_out  = overflow_reg;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Bench for ins_mem_loader (16-bit words, depth 4): directed scenarios plus
// randomized loads checked against a byte-list model of the program image.
module tb_ins_mem_loader;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          en  = 1'b0;
    logic          vld = 1'b0;
    logic [7:0]    rx  = '0;
    logic [AW-1:0] pc  = '0;
    logic [W-1:0]  ins;
    logic [AW:0]   cnt;
    logic          rdy;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    // Model: the bytes the loader should have accepted in the latest load.
    logic [7:0] mb[$];

    ins_mem_loader #(.INS_WIDTH(W), .DEPTH(D)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Load_INS_en_in (en),
        .Rx_Valid_in    (vld),
        .Rx_Byte_in     (rx),
        .PC_in          (pc),
        .INS_out        (ins),
        .Ins_Count_out  (cnt),
        .Ready_out      (rdy),
        .Overflow_out   (ovf)
    );

    always #5 CLK = ~CLK;

    function automatic int m_count();
        int n;
        n = mb.size() / 2;
        return (n > D) ? D : n;
    endfunction

    function automatic logic [W-1:0] m_word(input int i);
        if (i < m_count()) return {mb[2*i], mb[2*i+1]};
        return '0;
    endfunction

    function automatic logic m_ovf();
        return mb.size() > 2 * D;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Enable, stream bytes (optionally with idle gaps), disable. Optional
    // valid strobes in the enable-rise and enable-fall cycles must be ignored.
    task automatic do_load(input logic [7:0] bytes[$], input bit rise_v,
                           input bit fall_v, input bit gaps,
                           output logic [W-1:0] ins_mid);
        en = 1'b1; vld = rise_v; rx = 8'($urandom);
        tick();
        mb.delete();
        foreach (bytes[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                vld = 1'b0;
                tick();
            end
            vld = 1'b1; rx = bytes[i];
            mb.push_back(bytes[i]);
            tick();
        end
        ins_mid = ins;
        en = 1'b0; vld = fall_v; rx = 8'($urandom);
        tick();
        vld = 1'b0;
        $display("load: %0d bytes, count=%0d ready=%0b overflow=%0b",
                 bytes.size(), cnt, rdy, ovf);
    endtask

    task automatic do_read(input int p, output logic [W-1:0] v);
        pc = AW'(p);
        tick();
        v = ins;
        $display("read: pc=%0d ins=%h", p, v);
    endtask

    task automatic test_reset();
        en = 1'b1; vld = 1'b1; rx = 8'h77;
        repeat (3) tick();
        total++;
        if (ins !== '0 || cnt !== '0 || rdy !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got ins=%h cnt=%0d rdy=%0b ovf=%0b required all 0",
                     ins, cnt, rdy, ovf);
        end
        en = 1'b0; vld = 1'b0;
        RST = 1'b1;
        repeat (2) tick();
        total++;
        if (rdy !== 1'b0 || cnt !== '0) begin
            bad++;
            $display("FAIL idle_after_reset: got rdy=%0b cnt=%0d required 0/0", rdy, cnt);
        end
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        logic [W-1:0] v, mid;
        q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        do_load(q, 1'b0, 1'b0, 1'b0, mid);
        total++;
        if (mid !== '0) begin
            bad++; $display("FAIL ins_in_load: got %h required 0000", mid);
        end
        total++;
        if (cnt !== 3'd2 || rdy !== 1'b1 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL basic_status: got cnt=%0d rdy=%0b ovf=%0b required 2/1/0", cnt, rdy, ovf);
        end
        do_read(0, v);
        total++;
        if (v !== 16'h1234) begin bad++; $display("FAIL basic_pc0: got %h required 1234", v); end
        do_read(1, v);
        total++;
        if (v !== 16'hABCD) begin bad++; $display("FAIL basic_pc1: got %h required abcd", v); end
        do_read(2, v);
        total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL basic_pc2: got %h required 0000", v); end
    endtask

    task automatic test_partial();
        logic [7:0] q[$];
        logic [W-1:0] v, mid;
        q = '{8'h12, 8'h34, 8'h56};
        do_load(q, 1'b0, 1'b0, 1'b0, mid);
        total++;
        if (cnt !== 3'd1) begin bad++; $display("FAIL partial_count: got %0d required 1", cnt); end
        do_read(1, v);
        total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL partial_pc1: got %h required 0000", v); end
    endtask

    task automatic test_overflow();
        logic [7:0] q[$];
        logic [W-1:0] v, mid;
        logic [W-1:0] exp_w[4];
        exp_w = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        q.delete();
        for (int i = 1; i <= 10; i++) q.push_back(8'(i));
        do_load(q, 1'b0, 1'b0, 1'b0, mid);
        total++;
        if (cnt !== 3'd4 || ovf !== 1'b1) begin
            bad++; $display("FAIL overflow_status: got cnt=%0d ovf=%0b required 4/1", cnt, ovf);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(i, v);
            total++;
            if (v !== exp_w[i]) begin
                bad++; $display("FAIL overflow_word%0d: got %h required %h", i, v, exp_w[i]);
            end
        end
    endtask

    task automatic test_edge_bytes();
        logic [7:0] q[$];
        logic [W-1:0] v, mid;
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_load(q, 1'b1, 1'b1, 1'b0, mid);
        total++;
        if (cnt !== 3'd2) begin bad++; $display("FAIL edge_count: got %0d required 2", cnt); end
        do_read(0, v);
        total++;
        if (v !== 16'hAABB) begin bad++; $display("FAIL edge_pc0: got %h required aabb", v); end
        do_read(1, v);
        total++;
        if (v !== 16'hCCDD) begin bad++; $display("FAIL edge_pc1: got %h required ccdd", v); end
    endtask

    task automatic test_reload();
        logic [7:0] q[$];
        logic [W-1:0] v, mid;
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        do_load(q, 1'b0, 1'b0, 1'b0, mid);
        q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        do_load(q, 1'b0, 1'b0, 1'b0, mid);
        q = '{8'hEE, 8'hFF};
        do_load(q, 1'b0, 1'b0, 1'b0, mid);
        total++;
        if (cnt !== 3'd1 || ovf !== 1'b0 || rdy !== 1'b1) begin
            bad++;
            $display("FAIL reload_status: got cnt=%0d ovf=%0b rdy=%0b required 1/0/1", cnt, ovf, rdy);
        end
        do_read(0, v);
        total++;
        if (v !== 16'hEEFF) begin bad++; $display("FAIL reload_pc0: got %h required eeff", v); end
        do_read(1, v);
        total++;
        if (v !== 16'h0000) begin bad++; $display("FAIL reload_pc1: got %h required 0000", v); end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] q[$];
        logic [W-1:0] v, mid;
        en = 1'b1; vld = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            vld = 1'b1; rx = 8'(8'h30 + i);
            tick();
        end
        #2 RST = 1'b0;
        #1;
        total++;
        if (ins !== '0 || cnt !== '0 || rdy !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_load: got ins=%h cnt=%0d rdy=%0b ovf=%0b required all 0",
                     ins, cnt, rdy, ovf);
        end
        tick();
        en = 1'b0; vld = 1'b0;
        RST = 1'b1;
        repeat (3) tick();
        total++;
        if (rdy !== 1'b0 || cnt !== '0 || ins !== '0) begin
            bad++;
            $display("FAIL stays_idle: got rdy=%0b cnt=%0d ins=%h required 0/0/0", rdy, cnt, ins);
        end
        q = '{8'h5A, 8'hA5};
        do_load(q, 1'b0, 1'b0, 1'b0, mid);
        total++;
        if (cnt !== 3'd1 || rdy !== 1'b1) begin
            bad++; $display("FAIL fresh_load_status: got cnt=%0d rdy=%0b required 1/1", cnt, rdy);
        end
        do_read(0, v);
        total++;
        if (v !== 16'h5AA5) begin bad++; $display("FAIL fresh_load_pc0: got %h required 5aa5", v); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [W-1:0] v, mid;
        for (int it = 0; it < 12; it++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(0, 11)); i++) q.push_back(8'($urandom));
            do_load(q, 1'($urandom), 1'($urandom), 1'b1, mid);
            total++;
            if (cnt !== (AW+1)'(m_count()) || ovf !== m_ovf() || rdy !== 1'b1) begin
                bad++;
                $display("FAIL rand%0d_status: got cnt=%0d ovf=%0b rdy=%0b required %0d/%0b/1",
                         it, cnt, ovf, rdy, m_count(), m_ovf());
            end
            for (int k = 0; k < 6; k++) begin
                int p;
                p = int'($urandom_range(0, D - 1));
                do_read(p, v);
                total++;
                if (v !== m_word(p)) begin
                    bad++;
                    $display("FAIL rand%0d_read pc=%0d: got %h required %h", it, p, v, m_word(p));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_overflow();
        test_edge_bytes();
        test_reload();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ins_mem_loader.md
INS_MEM_LOADER -- requirements
Module: ins_mem_loader

Interface
REQ-001 SHALL have parameter INS_WIDTH, default 16; instruction width in bits, a multiple of 8 and at least 8.
REQ-002 SHALL have parameter DEPTH, default 16; number of instruction words, a power of 2 and at least 2.
REQ-003 SHALL derive localparams BYTES = INS_WIDTH/8 and ADDR_W = clog2(DEPTH).
REQ-004 Port CLK, input, 1 bit; clock; all state updates on its rising edge.
REQ-005 Port RST, input, 1 bit; reset, asynchronous, active-low.
REQ-006 Port Load_INS_en_in, input, 1 bit; from the Controller; high requests program-load mode.
REQ-007 Port Rx_Valid_in, input, 1 bit; from the RX UART interface; one-cycle strobe marking Rx_Byte_in valid.
REQ-008 Port Rx_Byte_in, input, 8 bits; received program byte.
REQ-009 Port PC_in, input, ADDR_W bits; fetch address from the Datapath.
REQ-010 Port INS_out, output, INS_WIDTH bits; fetched instruction to the Datapath.
REQ-011 Port Ins_Count_out, output, ADDR_W+1 bits; number of complete words stored.
REQ-012 Port Ready_out, output, 1 bit; high while in state READY.
REQ-013 Port Overflow_out, output, 1 bit; sticky flag, set when a byte is dropped because storage is full.

Function
REQ-014 SHALL implement a 3-state FSM with states IDLE, LOAD and READY.
REQ-015 IDLE -> LOAD when Load_INS_en_in=1; on entry, clear the byte counter, the word count and Overflow_out.
REQ-016 LOAD -> READY when Load_INS_en_in=0.
REQ-017 READY -> LOAD when Load_INS_en_in=1; on entry, apply the same clears as REQ-015.
REQ-018 SHALL accept bytes only in LOAD, only when Rx_Valid_in=1 and Load_INS_en_in=1 in that same cycle.
REQ-019 A byte presented in the cycle of the IDLE/READY -> LOAD transition SHALL be ignored.
REQ-020 A byte presented in the cycle Load_INS_en_in falls SHALL be ignored.
REQ-021 SHALL assemble each word big-endian: the first accepted byte goes to bits [INS_WIDTH-1:INS_WIDTH-8], and each following byte fills the next lower byte lane.
REQ-022 On the BYTES-th accepted byte, SHALL write the assembled word to mem[Ins_Count_out] in the same clock edge, increment Ins_Count_out and reset the byte counter to 0.
REQ-023 When BYTES=1, every accepted byte SHALL be written directly as one word.
REQ-024 When Ins_Count_out = DEPTH, SHALL drop further accepted bytes, set Overflow_out=1, and leave memory and the count unchanged; there is no wrap-around.
REQ-025 A partially assembled word at LOAD -> READY SHALL be discarded, with no write and no count change.
REQ-026 In READY, INS_out SHALL equal mem[PC_in] registered, with 1-cycle latency (the PC_in sampled at edge N appears after edge N).
REQ-027 In READY, if PC_in >= Ins_Count_out, INS_out SHALL be 0 (NOP) on the next cycle.
REQ-028 In IDLE and LOAD, INS_out SHALL be 0.
REQ-029 Memory array contents SHALL NOT require reset; a read never returns unwritten contents, per REQ-027.
REQ-030 Ins_Count_out and Overflow_out SHALL hold their values through READY.
REQ-031 Ready_out SHALL be a registered decode of the state, with no combinational path from inputs.

Reset
REQ-032 While RST=0, SHALL hold state=IDLE, INS_out=0, Ins_Count_out=0, Ready_out=0, Overflow_out=0, and the byte counter and assembly register at 0.
REQ-033 Reset asserted mid-LOAD or mid-READY SHALL abort immediately; after release the block stays in IDLE until Load_INS_en_in=1.
REQ-034 Reset release SHALL be synchronised externally; the block performs no reset synchronisation itself.

Verification (INS_WIDTH=16, DEPTH=4)
REQ-035 Load: enable, then bytes 12,34,AB,CD, then disable -> Ins_Count_out=2, Ready_out=1; PC_in=0 gives INS_out=1234 one cycle later; PC_in=1 gives ABCD.
REQ-036 Partial word: bytes 12,34,56, then disable -> Ins_Count_out=1; PC_in=1 gives INS_out=0000.
REQ-037 Overflow: 10 bytes 01..0A -> Ins_Count_out=4, Overflow_out=1; words 0102,0304,0506,0708; bytes 09 and 0A are dropped.
REQ-038 Edge bytes: a byte valid in the enable-rise cycle and a byte valid in the enable-fall cycle -> both ignored; the count reflects only the bytes in between.
REQ-039 Reload: from READY with count 2, re-enable and send EE,FF, then disable -> count=1, Overflow_out=0; PC_in=0 gives EEFF; PC_in=1 gives 0000.
REQ-040 Reset mid-LOAD after 3 bytes -> all outputs 0 and state IDLE; a fresh load of 2 bytes then yields count=1 with the correct word.
